bo_datapath: RTL and testbench

// Operative block (datapath) driven by the BC control FSM. It receives the BC control strobes LX, LS, LH and H, and returns

---
 rtl/bo_datapath_if.sv | 31 +++
 rtl/bo_datapath.sv | 72 +++++++
 tb/tb_bo_datapath.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/bo_datapath_if.sv
// Signal bundle between the BC control FSM (master) and the BO datapath (slave).
// It carries the control strobes, the operands, the status flags and the result handshake.
interface bo_datapath_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
);
    logic             LX;
    logic             LS;
    logic             LH;
    logic             H;
    logic             LR;
    logic [WIDTH-1:0] x_in;
    logic [CNT_W-1:0] n_in;
    logic             result_ready;
    logic [WIDTH-1:0] s_out;
    logic             h_zero;
    logic             ovf;
    logic             lr_busy;
    logic [WIDTH-1:0] result;
    logic             result_valid;

    modport master (
        output LX, LS, LH, H, LR, x_in, n_in, result_ready,
        input  s_out, h_zero, ovf, lr_busy, result, result_valid
    );

    modport slave (
        input  LX, LS, LH, H, LR, x_in, n_in, result_ready,
        output s_out, h_zero, ovf, lr_busy, result, result_valid
    );
endinterface

// File: rtl/bo_datapath.sv
// Datapath computing S = X * N by repeated addition under external strobe control.
// The final S is handed downstream through a valid/ready result register.
module bo_datapath #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input logic              clk,
    input logic              rst_n,
    bo_datapath_if.slave     bus
);
    logic [WIDTH-1:0] x_reg;
    logic [WIDTH-1:0] s_reg;
    logic [CNT_W-1:0] h_reg;
    logic             ovf_reg;
    logic [WIDTH-1:0] result_reg;
    logic             result_valid_reg;

    logic [WIDTH:0]   sum;
    logic             lr_accept;

    // The extra top bit of the sum captures the carry-out for the sticky overflow flag.
    assign sum       = {1'b0, s_reg} + {1'b0, x_reg};
    assign lr_accept = bus.LR & (~result_valid_reg | bus.result_ready);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_reg            <= '0;
            s_reg            <= '0;
            h_reg            <= '0;
            ovf_reg          <= 1'b0;
            result_reg       <= '0;
            result_valid_reg <= 1'b0;
        end else begin
            if (bus.LX) begin
                x_reg <= bus.x_in;
            end

            if (bus.LS) begin
                if (bus.H) begin
                    s_reg   <= sum[WIDTH-1:0];
                    ovf_reg <= ovf_reg | sum[WIDTH];
                end else begin
                    s_reg   <= '0;
                    ovf_reg <= 1'b0;
                end
            end

            // The counter saturates at zero rather than wrapping.
            if (bus.LH) begin
                if (!bus.H) begin
                    h_reg <= bus.n_in;
                end else if (h_reg != '0) begin
                    h_reg <= h_reg - CNT_W'(1);
                end
            end

            if (lr_accept) begin
                result_reg       <= s_reg;
                result_valid_reg <= 1'b1;
            end else if (result_valid_reg && bus.result_ready) begin
                result_valid_reg <= 1'b0;
            end
        end
    end

    assign bus.s_out        = s_reg;
    assign bus.h_zero       = (h_reg == '0);
    assign bus.ovf          = ovf_reg;
    assign bus.lr_busy      = result_valid_reg & ~bus.result_ready;
    assign bus.result       = result_reg;
    assign bus.result_valid = result_valid_reg;
endmodule

// File: tb/tb_bo_datapath.sv
// Directed self-checking bench for bo_datapath: multiply runs, overflow, strobe overlap,
// result handshake back-pressure, counter saturation and mid-run reset.
module tb_bo_datapath;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    bo_datapath_if #(.WIDTH(8), .CNT_W(4)) bus ();

    bo_datapath #(.WIDTH(8), .CNT_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    task automatic drive(input logic lx, input logic ls, input logic lh, input logic h, input logic lr);
        bus.LX = lx;
        bus.LS = ls;
        bus.LH = lh;
        bus.H  = h;
        bus.LR = lr;
    endtask

    // Advance one clock and sample 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;

        // 1: reset with every strobe asserted
        rst_n            = 1'b0;
        drive(1, 1, 1, 1, 1);
        bus.x_in         = 8'hFF;
        bus.n_in         = 4'hF;
        bus.result_ready = 1'b0;
        step();
        step();
        check("rst_s",       32'(bus.s_out), 0);
        check("rst_h_zero",  32'(bus.h_zero), 1);
        check("rst_ovf",     32'(bus.ovf), 0);
        check("rst_result",  32'(bus.result), 0);
        check("rst_valid",   32'(bus.result_valid), 0);
        check("rst_lr_busy", 32'(bus.lr_busy), 0);
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0);

        // 2: 5 * 3
        bus.x_in = 8'd5;
        bus.n_in = 4'd3;
        drive(1, 0, 0, 0, 0); step();
        drive(0, 1, 1, 0, 0); step();
        check("m1_init_s",      32'(bus.s_out), 0);
        check("m1_init_h_zero", 32'(bus.h_zero), 0);
        drive(0, 1, 1, 1, 0); step();
        check("m1_it1_s", 32'(bus.s_out), 5);
        check("m1_it1_hz", 32'(bus.h_zero), 0);
        step();
        check("m1_it2_s", 32'(bus.s_out), 10);
        check("m1_it2_hz", 32'(bus.h_zero), 0);
        step();
        check("m1_it3_s", 32'(bus.s_out), 15);
        check("m1_it3_hz", 32'(bus.h_zero), 1);
        check("m1_ovf",    32'(bus.ovf), 0);
        drive(0, 0, 0, 0, 1); step();
        check("m1_result",  32'(bus.result), 15);
        check("m1_valid",   32'(bus.result_valid), 1);
        check("m1_lr_busy", 32'(bus.lr_busy), 1);
        drive(0, 0, 0, 0, 0);
        bus.result_ready = 1'b1;
        step();
        check("m1_consumed", 32'(bus.result_valid), 0);
        bus.result_ready = 1'b0;

        // 3: 200 * 2 wraps to 144 with sticky overflow
        bus.x_in = 8'd200;
        bus.n_in = 4'd2;
        drive(1, 0, 0, 0, 0); step();
        drive(0, 1, 1, 0, 0); step();
        drive(0, 1, 1, 1, 0); step();
        check("m2_it1_s",   32'(bus.s_out), 200);
        check("m2_it1_ovf", 32'(bus.ovf), 0);
        step();
        check("m2_it2_s",   32'(bus.s_out), 144);
        check("m2_it2_ovf", 32'(bus.ovf), 1);
        check("m2_hz",      32'(bus.h_zero), 1);
        // 6a: counter at zero must not wrap
        drive(0, 0, 1, 1, 0); step();
        check("h_sat_hz", 32'(bus.h_zero), 1);
        drive(0, 1, 0, 0, 0); step();
        check("m2_clr_s",   32'(bus.s_out), 0);
        check("m2_clr_ovf", 32'(bus.ovf), 0);

        // 4: LX overlapping an accumulate uses the old X
        bus.x_in = 8'd4;
        drive(1, 0, 0, 0, 0); step();
        bus.x_in = 8'd9;
        drive(1, 1, 0, 1, 0); step();
        check("ovl_old_x", 32'(bus.s_out), 4);
        drive(0, 1, 0, 1, 0); step();
        check("ovl_new_x", 32'(bus.s_out), 13);

        // 5: result back-pressure
        drive(0, 0, 0, 0, 1); step();
        check("hs_load13",  32'(bus.result), 13);
        check("hs_valid13", 32'(bus.result_valid), 1);
        bus.x_in = 8'd7;
        drive(1, 1, 0, 0, 0); step();
        drive(0, 1, 0, 1, 0); step();
        check("hs_s7", 32'(bus.s_out), 7);
        drive(0, 0, 0, 0, 1); step();
        check("hs_blocked_result", 32'(bus.result), 13);
        check("hs_blocked_valid",  32'(bus.result_valid), 1);
        check("hs_blocked_busy",   32'(bus.lr_busy), 1);
        bus.result_ready = 1'b1;
        step();
        check("hs_swap_result", 32'(bus.result), 7);
        check("hs_swap_valid",  32'(bus.result_valid), 1);
        check("hs_swap_busy",   32'(bus.lr_busy), 0);
        drive(0, 0, 0, 0, 0); step();
        check("hs_drain_valid", 32'(bus.result_valid), 0);
        check("hs_drain_result", 32'(bus.result), 7);
        bus.result_ready = 1'b0;

        // 6b: reset in the middle of a run
        bus.x_in = 8'd3;
        bus.n_in = 4'd4;
        drive(1, 0, 0, 0, 0); step();
        drive(0, 1, 1, 0, 0); step();
        drive(0, 1, 1, 1, 0); step();
        drive(0, 1, 1, 1, 1); step();
        check("mr_pre_s",     32'(bus.s_out), 6);
        check("mr_pre_hz",    32'(bus.h_zero), 0);
        check("mr_pre_result", 32'(bus.result), 3);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("mr_s",      32'(bus.s_out), 0);
        check("mr_hz",     32'(bus.h_zero), 1);
        check("mr_result", 32'(bus.result), 0);
        check("mr_valid",  32'(bus.result_valid), 0);
        check("mr_ovf",    32'(bus.ovf), 0);
        drive(0, 1, 0, 1, 0); step();
        check("mr_x_cleared", 32'(bus.s_out), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
